bitstream_fifo_reader: RTL and testbench

//  Read-side consumer for dc_fifo in the single rd_clk domain. Pulls 16-bit words from the

---
 rtl/bitstream_fifo_reader.sv | 68 ++++++
 tb/tb_bitstream_fifo_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_fifo_reader.sv
// Bit-level front end for the stream parser: pulls 16-bit words from dc_fifo and
// exposes a left-aligned 32-bit peek window that downstream stages consume from.
module bitstream_fifo_reader #(
   parameter int data_bits   = 16,
   parameter int window_bits = 32,
   parameter int buf_bits    = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   output logic                                fifo_rd,
   input  logic [data_bits-1:0]                fifo_rd_data,
   input  logic                                fifo_rd_empty,
   input  logic                                flush,
   input  logic                                consume,
   input  logic [$clog2(window_bits+1)-1:0]    consume_len,
   output logic [window_bits-1:0]              bits_window,
   output logic [$clog2(buf_bits+1)-1:0]       bits_avail,
   output logic                                bits_valid
);

   localparam int cnt_w = $clog2(buf_bits + 1);
   localparam int len_w = $clog2(window_bits + 1);

   function automatic logic [len_w-1:0] clamp_len(input logic [len_w-1:0] len);
      if (len > len_w'(window_bits))
         return len_w'(window_bits);
      return len;
   endfunction

   logic [buf_bits-1:0] bit_buf;
   logic [buf_bits-1:0] buf_shift;
   logic [buf_bits-1:0] word_ext;
   logic [cnt_w-1:0]    cnt;
   logic [cnt_w-1:0]    cnt_after;
   logic [cnt_w-1:0]    shamt;
   logic [cnt_w:0]      committed;
   logic                pend;
   logic                eff_consume;

   assign bits_valid  = (cnt >= cnt_w'(window_bits));
   assign bits_avail  = cnt;
   assign bits_window = bit_buf[buf_bits-1 -: window_bits];

   assign eff_consume = consume & bits_valid;
   assign shamt       = eff_consume ? cnt_w'(clamp_len(consume_len)) : '0;
   assign buf_shift   = bit_buf << shamt;
   assign cnt_after   = cnt - shamt;
   // Bits below cnt are always zero, so the incoming word can simply be OR-ed in.
   assign word_ext    = {fifo_rd_data, {(buf_bits-data_bits){1'b0}}} >> cnt_after;

   // Pre-consume occupancy plus the in-flight word; conservative so no overflow is possible.
   assign committed = {1'b0, cnt} + (pend ? (cnt_w+1)'(data_bits) : '0);
   assign fifo_rd   = !rst && !flush && !fifo_rd_empty &&
                      (committed <= (cnt_w+1)'(buf_bits - data_bits));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         bit_buf <= '0;
         cnt     <= '0;
         pend    <= 1'b0;
      end else begin
         bit_buf <= pend ? (buf_shift | word_ext) : buf_shift;
         cnt     <= pend ? (cnt_after + cnt_w'(data_bits)) : cnt_after;
         pend    <= fifo_rd;
      end
   end

endmodule

// File: tb/tb_bitstream_fifo_reader.sv
// Directed bench for bitstream_fifo_reader with a behavioural one-cycle-latency FIFO.
module tb_bitstream_fifo_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_rd;
   logic [15:0] fifo_rd_data = 16'h0;
   logic        fifo_rd_empty;
   logic        flush;
   logic        consume;
   logic [5:0]  consume_len;
   logic [31:0] bits_window;
   logic [6:0]  bits_avail;
   logic        bits_valid;

   int passed = 0;
   int total  = 0;

   logic [15:0] mem [0:4095];
   int wr_ptr = 0;
   int rd_ptr = 0;

   bitstream_fifo_reader dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_rd       (fifo_rd),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .flush         (flush),
      .consume       (consume),
      .consume_len   (consume_len),
      .bits_window   (bits_window),
      .bits_avail    (bits_avail),
      .bits_valid    (bits_valid)
   );

   always #5 clk = ~clk;

   assign fifo_rd_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [15:0] w);
      mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   function automatic logic [15:0] stream_word(input int i);
      return 16'(i * 40503 + 4951);
   endfunction

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; consume = 1'b0; consume_len = 6'd0;
      push(16'hA5A5); push(16'h3C3C); push(16'hFFFF);
      repeat (2) @(negedge clk);
      total++; if (bits_avail !== 7'd0) $display("FAIL reset_avail: got %0d expected 0", bits_avail); else passed++;
      total++; if (bits_window !== 32'h0) $display("FAIL reset_window: got %h expected 00000000", bits_window); else passed++;
      total++; if (bits_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bits_valid); else passed++;
      total++; if (fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b expected 0", fifo_rd); else passed++;
   endtask

   task automatic test_startup();
      rst = 1'b0;
      #1;
      total++; if (fifo_rd !== 1'b1) $display("FAIL start_rd_c0: got %b expected 1", fifo_rd); else passed++;
      repeat (2) @(negedge clk);
      total++; if (bits_valid !== 1'b0) $display("FAIL start_valid_c2: got %b expected 0", bits_valid); else passed++;
      @(negedge clk);
      total++; if (bits_valid !== 1'b1) $display("FAIL start_valid_c3: got %b expected 1", bits_valid); else passed++;
      total++; if (bits_window !== 32'hA5A53C3C) $display("FAIL start_window: got %h expected a5a53c3c", bits_window); else passed++;
      total++; if (bits_avail !== 7'd32) $display("FAIL start_avail: got %0d expected 32", bits_avail); else passed++;
      total++; if (fifo_rd !== 1'b0) $display("FAIL start_rd_empty: got %b expected 0", fifo_rd); else passed++;
   endtask

   task automatic test_consume_append();
      consume = 1'b1; consume_len = 6'd4;
      @(negedge clk);
      total++; if (bits_window !== 32'h5A53C3CF) $display("FAIL consume4_window: got %h expected 5a53c3cf", bits_window); else passed++;
      total++; if (bits_avail !== 7'd44) $display("FAIL consume4_avail: got %0d expected 44", bits_avail); else passed++;
   endtask

   task automatic test_consume_invalid();
      consume = 1'b1; consume_len = 6'd24;
      @(negedge clk);
      total++; if (bits_avail !== 7'd20) $display("FAIL drain_avail: got %0d expected 20", bits_avail); else passed++;
      total++; if (bits_window !== 32'hCFFFF000) $display("FAIL drain_window: got %h expected cffff000", bits_window); else passed++;
      total++; if (bits_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", bits_valid); else passed++;
      consume_len = 6'd8;
      @(negedge clk);
      total++; if (bits_avail !== 7'd20) $display("FAIL ignored_avail: got %0d expected 20", bits_avail); else passed++;
      total++; if (bits_window !== 32'hCFFFF000) $display("FAIL ignored_window: got %h expected cffff000", bits_window); else passed++;
      consume = 1'b0;
      push(16'h1234);
      #1;
      total++; if (fifo_rd !== 1'b1) $display("FAIL refill_rd: got %b expected 1", fifo_rd); else passed++;
      repeat (2) @(negedge clk);
      total++; if (bits_avail !== 7'd36) $display("FAIL refill_avail: got %0d expected 36", bits_avail); else passed++;
      total++; if (bits_window !== 32'hCFFFF123) $display("FAIL refill_window: got %h expected cffff123", bits_window); else passed++;
      total++; if (bits_valid !== 1'b1) $display("FAIL refill_valid: got %b expected 1", bits_valid); else passed++;
   endtask

   task automatic test_flush();
      push(16'hBEEF); push(16'h7777);
      #1;
      total++; if (fifo_rd !== 1'b1) $display("FAIL flush_pre_rd: got %b expected 1", fifo_rd); else passed++;
      @(negedge clk);
      flush = 1'b1;
      #1;
      total++; if (fifo_rd !== 1'b0) $display("FAIL flush_rd_held: got %b expected 0", fifo_rd); else passed++;
      @(negedge clk);
      flush = 1'b0;
      total++; if (bits_avail !== 7'd0) $display("FAIL flush_avail: got %0d expected 0", bits_avail); else passed++;
      total++; if (bits_window !== 32'h0) $display("FAIL flush_window: got %h expected 00000000", bits_window); else passed++;
      #1;
      total++; if (fifo_rd !== 1'b1) $display("FAIL flush_resume_rd: got %b expected 1", fifo_rd); else passed++;
      repeat (2) @(negedge clk);
      total++; if (bits_avail !== 7'd16) $display("FAIL flush_after_avail: got %0d expected 16", bits_avail); else passed++;
      total++; if (bits_window !== 32'h77770000) $display("FAIL flush_after_window: got %h expected 77770000", bits_window); else passed++;
   endtask

   task automatic test_rst_inflight();
      push(16'h4242);
      #1;
      total++; if (fifo_rd !== 1'b1) $display("FAIL rstmid_pre_rd: got %b expected 1", fifo_rd); else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (fifo_rd !== 1'b0) $display("FAIL rstmid_rd: got %b expected 0", fifo_rd); else passed++;
      @(negedge clk);
      rst = 1'b0;
      total++; if (bits_avail !== 7'd0) $display("FAIL rstmid_avail: got %0d expected 0", bits_avail); else passed++;
      total++; if (bits_window !== 32'h0) $display("FAIL rstmid_window: got %h expected 00000000", bits_window); else passed++;
      total++; if (bits_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bits_valid); else passed++;
      @(negedge clk);
      total++; if (bits_avail !== 7'd0) $display("FAIL rstmid_late_avail: got %0d expected 0", bits_avail); else passed++;
   endtask

   task automatic test_back_to_back();
      int base;
      int j;
      int cyc;
      logic rd_prev;
      logic rd_exp;
      logic [31:0] exp_win;
      flush = 1'b1;
      base = wr_ptr;
      for (int i = 0; i < 1000; i++) push(stream_word(i));
      @(negedge clk);
      flush = 1'b0; consume = 1'b1; consume_len = 6'd32;
      rd_prev = 1'b0; j = 0; cyc = 0;
      while (j < 500 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         rd_exp = !fifo_rd_empty && ((32'(bits_avail) + (rd_prev ? 32'd16 : 32'd0)) <= 32'd48);
         total++; if (fifo_rd !== rd_exp) $display("FAIL b2b_rd cyc %0d: got %b expected %b", cyc, fifo_rd, rd_exp); else passed++;
         total++; if (bits_avail > 7'd64) $display("FAIL b2b_avail cyc %0d: got %0d expected <=64", cyc, bits_avail); else passed++;
         if (bits_valid === 1'b1) begin
            exp_win = {mem[base + 2*j], mem[base + 2*j + 1]};
            total++; if (bits_window !== exp_win) $display("FAIL b2b_window pair %0d: got %h expected %h", j, bits_window, exp_win); else passed++;
            j++;
         end
         rd_prev = fifo_rd;
      end
      total++; if (j != 500) $display("FAIL b2b_timeout: got %0d windows expected 500", j); else passed++;
      @(negedge clk);
      consume = 1'b0;
      total++; if (bits_avail !== 7'd0) $display("FAIL b2b_drained_avail: got %0d expected 0", bits_avail); else passed++;
   endtask

   task automatic test_clamp();
      int cyc;
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      cyc = 0;
      while (bits_avail !== 7'd64 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      total++; if (bits_avail !== 7'd64) $display("FAIL fill_avail: got %0d expected 64", bits_avail); else passed++;
      total++; if (bits_window !== 32'h11112222) $display("FAIL fill_window: got %h expected 11112222", bits_window); else passed++;
      consume = 1'b1; consume_len = 6'd0;
      @(negedge clk);
      total++; if (bits_avail !== 7'd64) $display("FAIL len0_avail: got %0d expected 64", bits_avail); else passed++;
      consume_len = 6'd40;
      @(negedge clk);
      consume = 1'b0;
      total++; if (bits_avail !== 7'd32) $display("FAIL clamp_avail: got %0d expected 32", bits_avail); else passed++;
      total++; if (bits_window !== 32'h33334444) $display("FAIL clamp_window: got %h expected 33334444", bits_window); else passed++;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_consume_append();
      test_consume_invalid();
      test_flush();
      test_rst_inflight();
      test_back_to_back();
      test_clamp();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
